// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the serial 4-tap FIR sequencer: state encoding,
// tap-count constants and the power-up coefficient set.
package fir_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MAC  = ST_MAC,
        S_OUT  = ST_OUT
    } state_t;

    localparam int NTAPS = 4;
    localparam int TAP_W = $clog2(NTAPS);

    localparam logic [7:0] DEF_H0 = 8'd5;
    localparam logic [7:0] DEF_H1 = 8'd6;
    localparam logic [7:0] DEF_H2 = 8'd7;
    localparam logic [7:0] DEF_H3 = 8'd8;

endpackage

// File: rtl/fir_tap_mac.sv
// The single shared multiply-accumulate: acc_out = acc_in + a*b.
// The product is kept at full width and the sum wraps at YW bits.
module fir_tap_mac #(
    parameter int CW = 8,
    parameter int XW = 8,
    parameter int YW = 16
) (
    input  logic [YW-1:0] acc_in,
    input  logic [CW-1:0] a,
    input  logic [XW-1:0] b,
    output logic [YW-1:0] acc_out
);

    logic [CW+XW-1:0] prod;

    assign prod    = {{XW{1'b0}}, a} * {{CW{1'b0}}, b};
    assign acc_out = acc_in + YW'(prod);

endmodule

// File: rtl/fir4_serial_mac_ctrl.sv
// Sequencer for a 4-tap unsigned FIR that time-shares one multiplier and one
// accumulator across all taps: accept a sample, run four MAC cycles, present
// the result on a valid/ready output, then return to IDLE for the next sample.
module fir4_serial_mac_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int            XW = 8,
    parameter int            CW = 8,
    parameter int            YW = 16,
    parameter logic [CW-1:0] H0 = DEF_H0,
    parameter logic [CW-1:0] H1 = DEF_H1,
    parameter logic [CW-1:0] H2 = DEF_H2,
    parameter logic [CW-1:0] H3 = DEF_H3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic          x_valid,
    output logic          x_ready,
    output logic [YW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready,
    input  logic          coef_we,
    input  logic [1:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          busy
);

    state_t             state_q;
    logic [TAP_W-1:0]   tap_q;
    logic [YW-1:0]      acc_q;
    logic [YW-1:0]      y_q;
    logic               y_valid_q;
    logic               x_ready_q;
    logic               busy_q;
    logic [XW-1:0]      d_q [NTAPS];
    logic [CW-1:0]      h_q [NTAPS];
    logic [YW-1:0]      mac_out;

    // Shared MAC: the tap counter selects which coefficient/sample pair feeds it.
    fir_tap_mac #(
        .CW (CW),
        .XW (XW),
        .YW (YW)
    ) u_mac (
        .acc_in  (acc_q),
        .a       (h_q[tap_q]),
        .b       (d_q[tap_q]),
        .acc_out (mac_out)
    );

    // FSM with registered handshake outputs, delay line, coefficient bank and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                d_q[i] <= '0;
            end
            h_q[0] <= H0;
            h_q[1] <= H1;
            h_q[2] <= H2;
            h_q[3] <= H3;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A write accepted alongside a sample is already visible
                    // to that sample, since MAC begins on the following cycle.
                    if (coef_we) begin
                        h_q[coef_addr] <= coef_data;
                    end
                    if (x_valid) begin
                        d_q[0]    <= x;
                        for (int i = 1; i < NTAPS; i++) begin
                            d_q[i] <= d_q[i-1];
                        end
                        acc_q     <= '0;
                        tap_q     <= '0;
                        x_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= mac_out;
                    if (tap_q == TAP_W'(NTAPS - 1)) begin
                        y_q       <= mac_out;
                        y_valid_q <= 1'b1;
                        state_q   <= S_OUT;
                    end else begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        x_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    y_valid_q <= 1'b0;
                    x_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign x_ready = x_ready_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fir4_serial_mac_ctrl.sv
// Bench for fir4_serial_mac_ctrl: a transaction-level model of the filter
// checked every cycle, plus directed scenarios with literal expected values.
module tb_fir4_serial_mac_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [15:0] y;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fir4_serial_mac_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Behavioural model: coefficient array, sample history, and one
    // outstanding result that becomes visible 5 cycles after acceptance.
    int unsigned mh [4];
    int unsigned md [4];
    bit          m_pend = 1'b0;
    int          m_acc = 0;
    int unsigned m_y = 0;
    int unsigned m_ylast = 0;
    int          mc = 0;
    bit          exp_yv;
    longint unsigned msum;

    always @(negedge clk) begin
        mc++;
        if (reset) begin
            mh = '{5, 6, 7, 8};
            md = '{0, 0, 0, 0};
            m_pend  = 1'b0;
            m_ylast = 0;
        end
        exp_yv = m_pend && ((mc - m_acc) >= 5);
        chk("mon_x_ready", x_ready, !m_pend);
        chk("mon_busy", busy, m_pend);
        chk("mon_y_valid", y_valid, exp_yv);
        chk("mon_y", y, exp_yv ? m_y : m_ylast);
        if (!reset) begin
            if (!m_pend) begin
                if (coef_we) mh[coef_addr] = coef_data;
                if (x_valid) begin
                    md[3] = md[2];
                    md[2] = md[1];
                    md[1] = md[0];
                    md[0] = x;
                    msum = 0;
                    for (int i = 0; i < 4; i++) msum += mh[i] * md[i];
                    m_y    = int'(msum % 65536);
                    m_pend = 1'b1;
                    m_acc  = mc;
                end
            end else if (exp_yv && y_ready) begin
                m_pend  = 1'b0;
                m_ylast = m_y;
            end
        end
    end

    // Send one sample and wait for its result; bw writes h0=9 while busy,
    // sw writes h0=3 in the same cycle as the accept.
    task automatic run_one(input logic [7:0] v, input bit bw, input bit sw,
                           output int yo, output int lat);
        int k;
        int t;
        k = 0;
        while (!x_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 100) chk("idle_timeout", 0, 1);
        x = v;
        x_valid = 1'b1;
        if (sw) begin
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd3;
        end
        @(posedge clk); #1;
        t = cyc;
        x_valid = 1'b0;
        coef_we = 1'b0;
        if (bw) begin
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd9;
        end
        k = 0;
        while (!y_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 50) chk("yvalid_timeout", 0, 1);
        coef_we = 1'b0;
        lat = cyc - t + 1;
        yo = int'(y);
        if (y_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] dv);
        int k;
        k = 0;
        while (!x_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        coef_we = 1'b1; coef_addr = a; coef_data = dv;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic flush(input int n);
        int yo, lat;
        for (int i = 0; i < n; i++) run_one(8'd0, 1'b0, 1'b0, yo, lat);
    endtask

    initial begin
        int yo, lat;
        int exp_imp [4];
        int exp_ramp [4];
        exp_imp  = '{5, 6, 7, 8};
        exp_ramp = '{5, 16, 34, 60};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_x_ready", x_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Impulse response with latency
        for (int i = 0; i < 4; i++) begin
            run_one((i == 0) ? 8'd1 : 8'd0, 1'b0, 1'b0, yo, lat);
            chk($sformatf("impulse_y%0d", i), yo, exp_imp[i]);
            chk($sformatf("impulse_lat%0d", i), lat, 5);
        end

        // Ramp
        for (int i = 0; i < 4; i++) begin
            run_one(8'(i + 1), 1'b0, 1'b0, yo, lat);
            chk($sformatf("ramp_y%0d", i), yo, exp_ramp[i]);
        end

        // Backpressure: hold y_ready low in OUT with a second sample offered
        flush(3);
        y_ready = 1'b0;
        run_one(8'd1, 1'b0, 1'b0, yo, lat);
        chk("bp_y", yo, 5);
        x = 8'd7;
        x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", y_valid, 1);
            chk("bp_hold_xready", x_ready, 0);
            chk("bp_hold_y", y, 5);
        end
        y_ready = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        chk("bp_release_valid", y_valid, 0);
        chk("bp_release_xready", x_ready, 1);
        chk("bp_release_busy", busy, 0);

        // Write while busy is ignored
        run_one(8'd0, 1'b1, 1'b0, yo, lat);
        chk("busywr_y", yo, 6);
        flush(2);
        run_one(8'd1, 1'b0, 1'b0, yo, lat);
        chk("busywr_impulse", yo, 5);

        // Write in IDLE takes effect
        wr(2'd0, 8'd9);
        flush(3);
        run_one(8'd1, 1'b0, 1'b0, yo, lat);
        chk("idlewr_impulse", yo, 9);

        // Write coincident with accept applies to that sample
        flush(3);
        run_one(8'd1, 1'b0, 1'b1, yo, lat);
        chk("samecyc_impulse", yo, 3);

        // Overflow wrap
        for (int i = 0; i < 4; i++) wr(2'(i), 8'd255);
        for (int i = 0; i < 4; i++) run_one(8'd255, 1'b0, 1'b0, yo, lat);
        chk("overflow_y4", yo, 63492);

        // Reset mid-MAC
        x = 8'd2;
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        chk("midmac_busy_before", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_x_ready", x_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        run_one(8'd1, 1'b0, 1'b0, yo, lat);
        chk("midrst_impulse", yo, 5);
        chk("midrst_lat", lat, 5);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d want=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
